count_sequencer: RTL and testbench



---
 rtl/count_sequencer.sv | 111 +++++++++++
 tb/tb_count_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// count_sequencer
//   Controller for an 8-bit enable-gated counter with async active-low clear.
//   Paces counter increments with a programmable rate divider and runs the
//   counter from 0 up to Limit, with start/clear, pause/resume and done.
//
// Ports:
//   Clock        in   system clock, rising edge
//   Clear_b      in   async active-low reset
//   Start        in   start (IDLE/DONE) or resume (PAUSE); Stop wins
//   Stop         in   pause while running
//   Sel[1:0]     in   rate select, indexes RELOAD0..3
//   Limit[7:0]   in   terminal count
//   CounterValue in   counter output fed back
//   CntEnable    out  one-cycle increment tick to the counter
//   CntClear_b   out  active-low clear request to the counter
//   Busy         out  high in CLEAR, RUN, PAUSE
//   Done         out  high in DONE
module count_sequencer #(
    parameter int              DIV_W   = 28,
    parameter logic [DIV_W-1:0] RELOAD0 = DIV_W'(0),
    parameter logic [DIV_W-1:0] RELOAD1 = DIV_W'(49999999),
    parameter logic [DIV_W-1:0] RELOAD2 = DIV_W'(99999999),
    parameter logic [DIV_W-1:0] RELOAD3 = DIV_W'(199999999)
) (
    input  logic       Clock,
    input  logic       Clear_b,
    input  logic       Start,
    input  logic       Stop,
    input  logic [1:0] Sel,
    input  logic [7:0] Limit,
    input  logic [7:0] CounterValue,
    output logic       CntEnable,
    output logic       CntClear_b,
    output logic       Busy,
    output logic       Done
);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, PAUSE, DONE} state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] div, div_next, reload_sel;
    logic             tick_next;
    logic [7:0]       eff_count;
    logic             at_limit;
    logic             go;

    always_comb begin
        case (Sel)
            2'd0:    reload_sel = RELOAD0;
            2'd1:    reload_sel = RELOAD1;
            2'd2:    reload_sel = RELOAD2;
            default: reload_sel = RELOAD3;
        endcase
    end

    // CntEnable is registered, so a tick issued last cycle has not yet shown
    // up on CounterValue. Counting it here keeps the limit check exact even
    // when ticks arrive every clock.
    assign eff_count = CounterValue + {7'd0, CntEnable};
    assign at_limit  = (eff_count == Limit);
    assign go        = Start & ~Stop;

    always_comb begin
        state_next = state;
        div_next   = div;
        tick_next  = 1'b0;
        case (state)
            IDLE, DONE: if (go) state_next = CLEAR;
            CLEAR: begin
                div_next   = reload_sel;
                state_next = RUN;
            end
            RUN: begin
                if (Stop) begin
                    state_next = PAUSE;
                end else if (at_limit) begin
                    state_next = DONE;
                end else if (div == '0) begin
                    tick_next = 1'b1;
                    div_next  = reload_sel;
                end else begin
                    div_next = div - 1'b1;
                end
            end
            PAUSE: if (go) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from next state so they line up with the state
    // register and carry no combinational path from the inputs.
    always_ff @(posedge Clock or negedge Clear_b) begin
        if (!Clear_b) begin
            state      <= IDLE;
            div        <= '0;
            CntEnable  <= 1'b0;
            CntClear_b <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            state      <= state_next;
            div        <= div_next;
            CntEnable  <= tick_next;
            CntClear_b <= (state_next != CLEAR);
            Busy       <= (state_next == CLEAR) || (state_next == RUN) ||
                          (state_next == PAUSE);
            Done       <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: drives a behavioural 8-bit counter from the
// DUT outputs and checks tick timing, final count and status against times
// computed arithmetically from the rate reloads and limit.
module tb_count_sequencer;

    logic       Clock = 1'b0;
    logic       Clear_b = 1'b0;
    logic       Start = 1'b0;
    logic       Stop = 1'b0;
    logic [1:0] Sel = 2'd0;
    logic [7:0] Limit = 8'd0;
    logic [7:0] cnt;
    logic       CntEnable, CntClear_b, Busy, Done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tick_q[$];
    int clr_q[$];
    int rl[4] = '{0, 3, 7, 15};

    count_sequencer #(
        .DIV_W  (28),
        .RELOAD0(28'd0),
        .RELOAD1(28'd3),
        .RELOAD2(28'd7),
        .RELOAD3(28'd15)
    ) dut (
        .Clock       (Clock),
        .Clear_b     (Clear_b),
        .Start       (Start),
        .Stop        (Stop),
        .Sel         (Sel),
        .Limit       (Limit),
        .CounterValue(cnt),
        .CntEnable   (CntEnable),
        .CntClear_b  (CntClear_b),
        .Busy        (Busy),
        .Done        (Done)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // the counter being controlled
    always @(posedge Clock or negedge CntClear_b)
        if (!CntClear_b) cnt <= 8'd0;
        else if (CntEnable) cnt <= cnt + 8'd1;

    always @(posedge Clock) begin
        #1;
        if (CntEnable === 1'b1) tick_q.push_back(cyc);
        if (CntClear_b === 1'b0) clr_q.push_back(cyc);
    end

    // Pulse Start; returns the cycle in which the DUT sits in CLEAR.
    task automatic pulse_start(input int sel, input int lim, output int s);
        @(negedge Clock);
        Sel = sel[1:0]; Limit = lim[7:0]; Start = 1'b1;
        tick_q.delete(); clr_q.delete();
        @(negedge Clock);
        Start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_done(input int budget, output int done_c, output bit seen);
        seen = 0; done_c = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge Clock);
            if (Done === 1'b1) begin seen = 1; done_c = cyc; end
        end
    endtask

    task automatic run_job(input int sel, input int lim, input string tag);
        int r, s, done_c, exp_done, bad;
        bit seen;
        r = rl[sel];
        pulse_start(sel, lim, s);
        wait_done(lim * (r + 1) + 10, done_c, seen);
        exp_done = s + 2 + lim * (r + 1);
        repeat (3) @(negedge Clock);
        checks++;
        if (!seen || done_c !== exp_done) begin
            errors++;
            $display("FAIL %s done_time: got %0d want %0d", tag, done_c - s, exp_done - s);
        end
        checks++;
        if (tick_q.size() !== lim) begin
            errors++;
            $display("FAIL %s tick_count: got %0d want %0d", tag, tick_q.size(), lim);
        end
        bad = -1;
        foreach (tick_q[k]) if (bad < 0 && tick_q[k] !== s + 2 + r + k * (r + 1)) bad = k;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s tick_pos[%0d]: got %0d want %0d", tag, bad,
                     tick_q[bad] - s, 2 + r + bad * (r + 1));
        end
        checks++;
        if (clr_q.size() !== 1 || clr_q[0] !== s) begin
            errors++;
            $display("FAIL %s clear_pulse: got %0d cycles want 1 at start", tag, clr_q.size());
        end
        checks++;
        if (cnt !== lim[7:0] || Busy !== 1'b0 || Done !== 1'b1) begin
            errors++;
            $display("FAIL %s final: got cnt=%0d busy=%b done=%b want cnt=%0d busy=0 done=1",
                     tag, cnt, Busy, Done, lim);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge Clock);
        checks++;
        if (CntEnable !== 1'b0 || CntClear_b !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals: got en=%b clr_b=%b busy=%b done=%b want 0 0 0 0",
                     CntEnable, CntClear_b, Busy, Done);
        end
        Clear_b = 1'b1;
        @(negedge Clock);
        checks++;
        if (CntClear_b !== 1'b1 || CntEnable !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got en=%b clr_b=%b busy=%b done=%b want 0 1 0 0",
                     CntEnable, CntClear_b, Busy, Done);
        end
    endtask

    task automatic test_idle_both;
        tick_q.delete(); clr_q.delete();
        Start = 1'b1; Stop = 1'b1;
        repeat (5) @(negedge Clock);
        Start = 1'b0; Stop = 1'b0;
        @(negedge Clock);
        checks++;
        if (Busy !== 1'b0 || clr_q.size() !== 0 || tick_q.size() !== 0) begin
            errors++;
            $display("FAIL idle_both: got busy=%b clears=%0d ticks=%0d want 0 0 0",
                     Busy, clr_q.size(), tick_q.size());
        end
    endtask

    task automatic test_random;
        int sel, lim;
        for (int j = 0; j < 5; j++) begin
            sel = $urandom_range(0, 2);
            lim = $urandom_range(0, 12);
            run_job(sel, lim, $sformatf("rand%0d", j));
        end
    endtask

    task automatic test_pause;
        int s, a, done_c, bad;
        bit seen;
        pulse_start(2, 10, s);
        a = -1;
        for (int i = 0; i < 40 && a < 0; i++) begin
            @(negedge Clock);
            if (tick_q.size() == 2) a = cyc;
        end
        checks++;
        if (a !== s + 17) begin
            errors++;
            $display("FAIL pause_tick2: got %0d want %0d", a - s, 17);
        end
        Stop = 1'b1;
        repeat (10) @(negedge Clock);
        Start = 1'b1;                 // both high while paused: stays paused
        repeat (10) @(negedge Clock);
        Stop = 1'b0;
        @(negedge Clock);
        Start = 1'b0;
        checks++;
        if (tick_q.size() !== 2 || cnt !== 8'd2 || Busy !== 1'b1 || clr_q.size() !== 1) begin
            errors++;
            $display("FAIL pause_hold: got ticks=%0d cnt=%0d busy=%b clears=%0d want 2 2 1 1",
                     tick_q.size(), cnt, Busy, clr_q.size());
        end
        // stop cycle plus 20 paused cycles shift the remaining schedule by 21
        wait_done(120, done_c, seen);
        repeat (3) @(negedge Clock);
        checks++;
        if (!seen || done_c !== s + 103) begin
            errors++;
            $display("FAIL pause_done_time: got %0d want %0d", done_c - s, 103);
        end
        bad = -1;
        foreach (tick_q[k])
            if (bad < 0 && k >= 2 && tick_q[k] !== s + 9 + 8 * k + 21) bad = k;
        checks++;
        if (bad >= 0 || tick_q.size() !== 10 || cnt !== 8'd10) begin
            errors++;
            $display("FAIL pause_resume: got ticks=%0d cnt=%0d bad_idx=%0d want 10 10 -1",
                     tick_q.size(), cnt, bad);
        end
    endtask

    task automatic test_run_both;
        int s, a, done_c;
        bit seen;
        pulse_start(1, 20, s);
        a = -1;
        for (int i = 0; i < 30 && a < 0; i++) begin
            @(negedge Clock);
            if (tick_q.size() == 2) a = cyc;
        end
        Start = 1'b1; Stop = 1'b1;
        repeat (6) @(negedge Clock);
        checks++;
        if (a < 0 || tick_q.size() !== 2 || cnt !== 8'd2 || Busy !== 1'b1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL run_both_pause: got ticks=%0d cnt=%0d busy=%b done=%b want 2 2 1 0",
                     tick_q.size(), cnt, Busy, Done);
        end
        Stop = 1'b0;
        @(negedge Clock);
        Start = 1'b0;
        wait_done(120, done_c, seen);
        checks++;
        if (!seen || cnt !== 8'd20 || tick_q.size() !== 20) begin
            errors++;
            $display("FAIL run_both_finish: got done=%b cnt=%0d ticks=%0d want 1 20 20",
                     seen, cnt, tick_q.size());
        end
    endtask

    task automatic test_midreset;
        int s, a;
        pulse_start(3, 200, s);
        a = -1;
        for (int i = 0; i < 60 && a < 0; i++) begin
            @(negedge Clock);
            if (tick_q.size() == 2) a = cyc;
        end
        #1 Clear_b = 1'b0;
        #1;
        checks++;
        if (a < 0 || CntEnable !== 1'b0 || CntClear_b !== 1'b0 || Busy !== 1'b0 ||
            Done !== 1'b0 || cnt !== 8'd0) begin
            errors++;
            $display("FAIL midreset_async: got en=%b clr_b=%b busy=%b done=%b cnt=%0d want 0 0 0 0 0",
                     CntEnable, CntClear_b, Busy, Done, cnt);
        end
        @(negedge Clock);
        Clear_b = 1'b1;
        tick_q.delete();
        repeat (40) @(negedge Clock);
        checks++;
        if (tick_q.size() !== 0 || Busy !== 1'b0 || Done !== 1'b0 || CntClear_b !== 1'b1) begin
            errors++;
            $display("FAIL midreset_idle: got ticks=%0d busy=%b done=%b clr_b=%b want 0 0 0 1",
                     tick_q.size(), Busy, Done, CntClear_b);
        end
    endtask

    initial begin
        test_reset();
        test_idle_both();
        run_job(0, 5, "fast");
        run_job(1, 3, "rate");
        run_job(0, 0, "limit0");
        run_job(0, 2, "from_done");
        test_random();
        run_job(0, 255, "limit255");
        test_pause();
        test_run_both();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
